// File: rtl/fpmul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fpmul_pipe (with helper fpmul_elem)                         |
// | Description : 3-stage pipelined IEEE-754 multiplier, LANES x 32-bit lanes,|
// |               one fp32 or two packed fp16 products per lane, RNE with     |
// |               gradual underflow, valid/ready handshakes, sticky flags.    |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+

// One multiplier element for a single format (EW exponent bits, MW fraction bits).
module fpmul_elem #(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_en,
   input  logic [EW+MW:0] i_a,
   input  logic [EW+MW:0] i_b,
   output logic [EW+MW:0] o_d,
   output logic [3:0]     o_flags
);
   localparam int c_P    = 2 * MW + 2;          // significand product width
   localparam int c_XW   = EW + 4;              // working exponent width (two's complement)
   localparam int c_BIAS = (1 << (EW - 1)) - 1;
   localparam int c_EMAX = (1 << EW) - 1;

   localparam logic [1:0] c_CL_FIN  = 2'd0;
   localparam logic [1:0] c_CL_NAN  = 2'd1;
   localparam logic [1:0] c_CL_INF  = 2'd2;
   localparam logic [1:0] c_CL_ZERO = 2'd3;

   // ---------------- S1: unpack / classify / multiply ----------------
   logic [EW-1:0]   w_ea, w_eb;
   logic [MW-1:0]   w_ma, w_mb;
   logic            w_a_zero, w_b_zero, w_a_inf, w_b_inf;
   logic            w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_infzero;
   logic [MW:0]     w_sa, w_sb;
   logic [c_XW-1:0] w_xa, w_xb, w_esum;
   logic [c_P-1:0]  w_prod;
   logic [1:0]      w_cls;
   logic            w_nv;

   assign w_ea      = i_a[EW+MW-1:MW];
   assign w_eb      = i_b[EW+MW-1:MW];
   assign w_ma      = i_a[MW-1:0];
   assign w_mb      = i_b[MW-1:0];
   assign w_a_zero  = (w_ea == '0) && (w_ma == '0);
   assign w_b_zero  = (w_eb == '0) && (w_mb == '0);
   assign w_a_inf   = (w_ea == '1) && (w_ma == '0);
   assign w_b_inf   = (w_eb == '1) && (w_mb == '0);
   assign w_a_nan   = (w_ea == '1) && (w_ma != '0);
   assign w_b_nan   = (w_eb == '1) && (w_mb != '0);
   assign w_a_snan  = w_a_nan && !w_ma[MW-1];
   assign w_b_snan  = w_b_nan && !w_mb[MW-1];
   assign w_infzero = (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);

   // Denorms have no hidden bit and an effective biased exponent of 1.
   assign w_sa   = {w_ea != '0, w_ma};
   assign w_sb   = {w_eb != '0, w_mb};
   assign w_xa   = (w_ea == '0) ? c_XW'(1) : c_XW'(w_ea);
   assign w_xb   = (w_eb == '0) ? c_XW'(1) : c_XW'(w_eb);
   assign w_esum = w_xa + w_xb - c_XW'(c_BIAS);
   assign w_prod = c_P'(w_sa) * c_P'(w_sb);

   // Special-case class in priority order: NaN (incl. inf*0), inf, zero, finite.
   always_comb begin
      w_nv  = w_a_snan || w_b_snan || w_infzero;
      w_cls = c_CL_FIN;
      if (w_a_nan || w_b_nan || w_infzero)
         w_cls = c_CL_NAN;
      else if (w_a_inf || w_b_inf)
         w_cls = c_CL_INF;
      else if (w_a_zero || w_b_zero)
         w_cls = c_CL_ZERO;
   end

   logic            r1_sign, r1_nv;
   logic [1:0]      r1_cls;
   logic [c_P-1:0]  r1_prod;
   logic [c_XW-1:0] r1_exp;

   // S1 register: product, exponent sum and class.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_sign <= 1'b0;
         r1_nv   <= 1'b0;
         r1_cls  <= c_CL_ZERO;
         r1_prod <= '0;
         r1_exp  <= '0;
      end else if (i_en) begin
         r1_sign <= i_a[EW+MW] ^ i_b[EW+MW];
         r1_nv   <= w_nv;
         r1_cls  <= w_cls;
         r1_prod <= w_prod;
         r1_exp  <= w_esum;
      end
   end

   // ---------------- S2: normalise / denormalise ----------------
   function automatic logic [c_XW-1:0] f_lzc(input logic [c_P-1:0] v);
      f_lzc = c_XW'(c_P);
      for (int i = 0; i < c_P; i++)
         if (v[i]) f_lzc = c_XW'(c_P - 1 - i);
   endfunction

   logic [c_XW-1:0] w_lz, w_e, w_sh;
   logic [c_P-1:0]  w_norm, w_den, w_sel;
   logic            w_tiny, w_lost, w_stk;

   assign w_lz   = f_lzc(r1_prod);
   assign w_norm = r1_prod << w_lz;
   // Biased exponent of the value once its leading one sits at bit c_P-1.
   assign w_e    = r1_exp + c_XW'(1) - w_lz;
   assign w_tiny = $signed(w_e) < $signed(c_XW'(1));
   assign w_sh   = c_XW'(1) - w_e;

   // Right shift into the denormal range, folding lost bits into sticky.
   always_comb begin
      w_den  = '0;
      w_lost = 1'b0;
      if (w_sh >= c_XW'(c_P)) begin
         w_den  = '0;
         w_lost = |w_norm;
      end else begin
         w_den  = w_norm >> w_sh;
         w_lost = |(w_norm & ~({c_P{1'b1}} << w_sh));
      end
   end

   assign w_sel = w_tiny ? w_den : w_norm;
   assign w_stk = (|w_sel[MW-1:0]) || (w_tiny && w_lost);

   logic            r2_sign, r2_nv, r2_rnd, r2_stk, r2_tiny;
   logic [1:0]      r2_cls;
   logic [MW-1:0]   r2_mant;
   logic [c_XW-1:0] r2_exp;

   // S2 register: kept fraction, round/sticky bits and exponent field.
   always_ff @(posedge clk) begin
      if (rst) begin
         r2_sign <= 1'b0;
         r2_nv   <= 1'b0;
         r2_cls  <= c_CL_ZERO;
         r2_mant <= '0;
         r2_rnd  <= 1'b0;
         r2_stk  <= 1'b0;
         r2_tiny <= 1'b0;
         r2_exp  <= '0;
      end else if (i_en) begin
         r2_sign <= r1_sign;
         r2_nv   <= r1_nv;
         r2_cls  <= r1_cls;
         r2_mant <= w_sel[2*MW:MW+1];
         r2_rnd  <= w_sel[MW];
         r2_stk  <= w_stk;
         r2_tiny <= w_tiny;
         // The hidden bit is 1 only for a normal result: encode exp field 0 otherwise.
         r2_exp  <= w_sel[c_P-1] ? w_e : '0;
      end
   end

   // ---------------- S3: round / pack ----------------
   logic            w_inc, w_ovf, w_nx;
   logic [MW:0]     w_msum;
   logic [c_XW-1:0] w_ef;
   logic [EW+MW:0]  w_d;
   logic [3:0]      w_fl;

   // A fraction carry spills into the exponent: renormalises, or lifts a denorm to min normal.
   assign w_inc  = r2_rnd && (r2_stk || r2_mant[0]);
   assign w_msum = {1'b0, r2_mant} + (MW+1)'(w_inc);
   assign w_ef   = r2_exp + c_XW'(w_msum[MW]);
   assign w_ovf  = w_ef >= c_XW'(c_EMAX);
   assign w_nx   = r2_rnd || r2_stk;

   // Result and per-element flags selection.
   always_comb begin
      w_d  = '0;
      w_fl = {r2_nv, 3'b000};
      case (r2_cls)
         c_CL_NAN:  w_d = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
         c_CL_INF:  w_d = {r2_sign, {EW{1'b1}}, {MW{1'b0}}};
         c_CL_ZERO: w_d = {r2_sign, {(EW+MW){1'b0}}};
         default: begin
            if (w_ovf) begin
               w_d  = {r2_sign, {EW{1'b1}}, {MW{1'b0}}};
               w_fl = 4'b0101;
            end else begin
               w_d  = {r2_sign, w_ef[EW-1:0], w_msum[MW-1:0]};
               w_fl = {2'b00, r2_tiny && w_nx, w_nx};
            end
         end
      endcase
   end

   logic [EW+MW:0] r3_d;
   logic [3:0]     r3_fl;

   // S3 register: packed result and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r3_d  <= '0;
         r3_fl <= '0;
      end else if (i_en) begin
         r3_d  <= w_d;
         r3_fl <= w_fl;
      end
   end

   assign o_d     = r3_d;
   assign o_flags = r3_fl;
endmodule

// Top level: lanes, handshake control, tag/precision pipe and sticky flags.
module fpmul_pipe #(
   parameter int LANES = 2,
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_precision,
   input  logic [32*LANES-1:0]   in_a,
   input  logic [32*LANES-1:0]   in_b,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [32*LANES-1:0]   out_d,
   output logic                  out_precision,
   output logic [TAG_W-1:0]      out_tag,
   input  logic                  flag_clr,
   output logic [3:0]            flags
);
   logic             w_en;
   logic             r1_v, r2_v, r3_v;
   logic             r1_prec, r2_prec, r3_prec;
   logic [TAG_W-1:0] r1_tag, r2_tag, r3_tag;
   logic [3:0]       r_flags;
   logic [3:0]       w_newfl;
   logic [3:0]       w_fl32 [LANES];
   logic [3:0]       w_fl16 [LANES];

   // The whole pipe advances together; only a held output stalls it.
   assign w_en     = !r3_v || out_ready;
   assign in_ready = w_en;

   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         logic [31:0] w_d32;
         logic [15:0] w_dlo, w_dhi;
         logic [3:0]  w_flo, w_fhi;

         fpmul_elem #(.EW(8), .MW(23)) u_f32 (
            .clk(clk), .rst(rst), .i_en(w_en),
            .i_a(in_a[32*l +: 32]), .i_b(in_b[32*l +: 32]),
            .o_d(w_d32), .o_flags(w_fl32[l])
         );
         fpmul_elem #(.EW(5), .MW(10)) u_f16_lo (
            .clk(clk), .rst(rst), .i_en(w_en),
            .i_a(in_a[32*l +: 16]), .i_b(in_b[32*l +: 16]),
            .o_d(w_dlo), .o_flags(w_flo)
         );
         fpmul_elem #(.EW(5), .MW(10)) u_f16_hi (
            .clk(clk), .rst(rst), .i_en(w_en),
            .i_a(in_a[32*l+16 +: 16]), .i_b(in_b[32*l+16 +: 16]),
            .o_d(w_dhi), .o_flags(w_fhi)
         );

         assign w_fl16[l]         = w_flo | w_fhi;
         assign out_d[32*l +: 32] = r3_prec ? w_d32 : {w_dhi, w_dlo};
      end
   endgenerate

   // OR the flags of the elements that belong to the output transaction's format.
   always_comb begin
      w_newfl = '0;
      for (int l = 0; l < LANES; l++)
         w_newfl = w_newfl | (r3_prec ? w_fl32[l] : w_fl16[l]);
   end

   // Valid, precision and tag travel alongside the data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_v    <= 1'b0;
         r2_v    <= 1'b0;
         r3_v    <= 1'b0;
         r1_prec <= 1'b0;
         r2_prec <= 1'b0;
         r3_prec <= 1'b0;
         r1_tag  <= '0;
         r2_tag  <= '0;
         r3_tag  <= '0;
      end else if (w_en) begin
         r1_v    <= in_valid;
         r2_v    <= r1_v;
         r3_v    <= r2_v;
         r1_prec <= in_precision;
         r2_prec <= r1_prec;
         r3_prec <= r2_prec;
         r1_tag  <= in_tag;
         r2_tag  <= r1_tag;
         r3_tag  <= r2_tag;
      end
   end

   // Sticky flags: a clear never drops flags from a simultaneous output handshake.
   always_ff @(posedge clk) begin
      if (rst)
         r_flags <= '0;
      else if (r3_v && out_ready)
         r_flags <= (flag_clr ? 4'b0000 : r_flags) | w_newfl;
      else if (flag_clr)
         r_flags <= '0;
   end

   assign out_valid     = r3_v;
   assign out_precision = r3_prec;
   assign out_tag       = r3_tag;
   assign flags         = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_fpmul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fpmul_pipe                                               |
// | Description : Directed self-checking bench for fpmul_pipe.                |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_fpmul_pipe;
   localparam int LANES = 2;
   localparam int TAG_W = 4;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_precision;
   logic        out_valid, out_ready, out_precision, flag_clr;
   logic [63:0] in_a, in_b, out_d;
   logic [3:0]  in_tag, out_tag, flags;

   int   vectors = 0;
   int   miscompares = 0;
   int   ni, no, stall;
   logic first, hs_in;

   logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};
   logic [31:0] bp_q [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                             32'h41000000, 32'h41200000, 32'h41400000};

   // Free-running clock.
   always #5 clk = ~clk;

   fpmul_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_precision(in_precision),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
      .out_precision(out_precision), .out_tag(out_tag),
      .flag_clr(flag_clr), .flags(flags)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", nm, obs, exp);
      end
   endtask

   task automatic send(input logic prec, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag);
      in_valid     = 1'b1;
      in_precision = prec;
      in_a         = a;
      in_b         = b;
      in_tag       = tag;
      step;
      in_valid     = 1'b0;
   endtask

   // lat counts the handshake cycle as 1; the handshake edge already passed inside send.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 12) begin
         step;
         lat++;
      end
   endtask

   task automatic xact(input string nm, input logic prec, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] tag, input logic [63:0] exp_d,
                       input logic clr, input logic [3:0] exp_fl);
      int lat;
      send(prec, a, b, tag);
      wait_out(lat);
      chk({nm, "_lat"},  64'(lat), 64'd3);
      chk({nm, "_d"},    out_d, exp_d);
      chk({nm, "_tag"},  64'(out_tag), 64'(tag));
      chk({nm, "_prec"}, 64'(out_precision), 64'(prec));
      flag_clr = clr;
      step;
      chk({nm, "_flags"}, 64'(flags), 64'(exp_fl));
   endtask

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_precision = 1'b0; in_a = '0; in_b = '0;
      in_tag = '0; out_ready = 1'b1; flag_clr = 1'b0;
      step;
      step;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_d",     out_d, 64'd0);
      chk("rst_out_tag",   64'(out_tag), 64'd0);
      chk("rst_out_prec",  64'(out_precision), 64'd0);
      chk("rst_flags",     64'(flags), 64'd0);
      chk("rst_in_ready",  64'(in_ready), 64'd1);
      rst = 1'b0;
      step;

      // fp32 1.5 * 2 = 3; lane1 1 * 1
      xact("f32_basic", 1'b1, {32'h3F800000, 32'h3FC00000}, {32'h3F800000, 32'h40000000},
           4'd5, {32'h3F800000, 32'h40400000}, 1'b0, 4'b0000);
      // fp16 pairs: 1*3, 2*0.5, 1*1, 1*1
      xact("f16_basic", 1'b0, {32'h3C003C00, 32'h3C004000}, {32'h3C003C00, 32'h42003800},
           4'd2, {32'h3C003C00, 32'h42003C00}, 1'b0, 4'b0000);
      // fp32 2^127 * 2 overflows: OF|NX
      xact("f32_ovf", 1'b1, {32'h3F800000, 32'h7F000000}, {32'h3F800000, 32'h40000000},
           4'd3, {32'h3F800000, 32'h7F800000}, 1'b0, 4'b0101);
      // inf * 0 gives canonical qNaN; clear on the same handshake keeps NV only
      xact("f32_infzero", 1'b1, {32'h3F800000, 32'h7F800000}, {32'h3F800000, 32'h00000000},
           4'd4, {32'h3F800000, 32'h7FC00000}, 1'b1, 4'b1000);
      step;
      chk("flag_clr_idle", 64'(flags), 64'd0);
      flag_clr = 1'b0;

      // fp16 denormal rounding
      xact("f16_den_tie0", 1'b0, {32'h3C003C00, 32'h3C000001}, {32'h3C003C00, 32'h3C003800},
           4'd6, {32'h3C003C00, 32'h3C000000}, 1'b0, 4'b0011);
      xact("f16_den_tie1", 1'b0, {32'h3C003C00, 32'h3C000003}, {32'h3C003C00, 32'h3C003800},
           4'd7, {32'h3C003C00, 32'h3C000002}, 1'b0, 4'b0011);
      xact("f16_den_up",   1'b0, {32'h3C003C00, 32'h3C0003FF}, {32'h3C003C00, 32'h3C003C01},
           4'd8, {32'h3C003C00, 32'h3C000400}, 1'b0, 4'b0011);
      flag_clr = 1'b1;
      step;
      flag_clr = 1'b0;
      chk("flags_cleared", 64'(flags), 64'd0);

      // Backpressure: six back-to-back inputs, 5-cycle output stall
      ni = 0; no = 0; stall = 0; first = 1'b0;
      for (int cyc = 0; cyc < 40 && no < 6; cyc++) begin
         if (!first && out_valid) begin
            first = 1'b1;
            stall = 5;
         end
         out_ready = (stall == 0);
         in_valid  = (ni < 6);
         if (ni < 6) begin
            in_precision = 1'b1;
            in_a   = {32'h3F800000, bp_a[ni]};
            in_b   = {32'h3F800000, 32'h40000000};
            in_tag = 4'(8 + ni);
         end
         #1;
         if (stall > 0) begin
            chk("bp_in_ready_stall", 64'(in_ready), 64'd0);
            chk("bp_hold_d",   out_d, {32'h3F800000, bp_q[no]});
            chk("bp_hold_tag", 64'(out_tag), 64'(8 + no));
            stall--;
         end
         if (out_valid && out_ready) begin
            chk("bp_d",   out_d, {32'h3F800000, bp_q[no]});
            chk("bp_tag", 64'(out_tag), 64'(8 + no));
            no++;
         end
         hs_in = in_valid && in_ready;
         step;
         if (hs_in) ni++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_count", 64'(no), 64'd6);
      step;
      step;
      chk("bp_drained", 64'(out_valid), 64'd0);

      // Reset with two overflowing transactions in flight
      send(1'b1, {32'h3F800000, 32'h7F000000}, {32'h3F800000, 32'h40000000}, 4'hA);
      send(1'b1, {32'h3F800000, 32'h7F000000}, {32'h3F800000, 32'h40000000}, 4'hB);
      rst = 1'b1;
      step;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("rst_flush_valid", 64'(out_valid), 64'd0);
         step;
      end
      chk("rst_flush_flags", 64'(flags), 64'd0);
      xact("post_rst", 1'b1, {32'h3F800000, 32'h3FC00000}, {32'h3F800000, 32'h40000000},
           4'd7, {32'h3F800000, 32'h40400000}, 1'b0, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
